// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, drives the instruction ROM and fills IF/ID for the 5-stage MIPS pipeline.
// Optional FETCH_KERNEL_MODE_EN: pc[31] marks supervisor mode, masks irq_i and is preserved by pc+4.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_tgt_i,
    input  logic        exc_i,
    input  logic        jump_i,
    input  logic [31:0] jump_tgt_i,
    input  logic        irq_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic        flush_id_o,
    output logic        k0_we_o,
    output logic [31:0] k0_data_o
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
    logic            irq_take;

    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] instr_nxt;
    logic [XLEN-1:0] pc4_nxt;
    logic            valid_nxt;
    logic            k0_we_nxt;
    logic [XLEN-1:0] k0_data_nxt;
    logic            redirect;

`ifdef FETCH_KERNEL_MODE_EN
    assign pc_inc   = {pc[XLEN-1], pc[XLEN-2:0] + (XLEN-1)'(4)};
    assign irq_take = irq_i & ~stall_i & ~pc[XLEN-1];
`else
    assign pc_inc   = pc + XLEN'(4);
    assign irq_take = irq_i & ~stall_i;
`endif

    assign imem_addr_o = pc;
    assign flush_id_o  = branch_i | exc_i;

    // Next-PC arbitration: branch > exception > jump > irq > stall > sequential.
    always_comb begin
        pc_nxt      = pc;
        instr_nxt   = ifid_instr_o;
        pc4_nxt     = ifid_pc4_o;
        valid_nxt   = ifid_valid_o;
        k0_we_nxt   = 1'b0;
        k0_data_nxt = k0_data_o;
        redirect    = 1'b0;

        if (branch_i) begin
            pc_nxt   = branch_tgt_i;
            redirect = 1'b1;
        end else if (exc_i) begin
            pc_nxt      = EXC_VEC;
            redirect    = 1'b1;
            k0_we_nxt   = 1'b1;
            k0_data_nxt = ifid_pc4_o;
        end else if (jump_i) begin
            pc_nxt   = jump_tgt_i;
            redirect = 1'b1;
        end else if (irq_take) begin
            pc_nxt      = IRQ_VEC;
            redirect    = 1'b1;
            k0_we_nxt   = 1'b1;
            k0_data_nxt = pc;
        end else if (!stall_i) begin
            pc_nxt    = pc_inc;
            instr_nxt = imem_instr_i;
            pc4_nxt   = pc_inc;
            valid_nxt = 1'b1;
        end

        // No delay slot: every redirect squashes the word being fetched.
        if (redirect) begin
            instr_nxt = '0;
            pc4_nxt   = '0;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_VEC;
            ifid_instr_o <= '0;
            ifid_pc4_o   <= '0;
            ifid_valid_o <= 1'b0;
            k0_we_o      <= 1'b0;
            k0_data_o    <= '0;
        end else begin
            pc           <= pc_nxt;
            ifid_instr_o <= instr_nxt;
            ifid_pc4_o   <= pc4_nxt;
            ifid_valid_o <= valid_nxt;
            k0_we_o      <= k0_we_nxt;
            k0_data_o    <= k0_data_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios followed by randomized redirect/stall/irq traffic.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_V = 32'h8000_0000;
    localparam logic [31:0] IRQ_V = 32'h8000_0004;
    localparam logic [31:0] EXC_V = 32'h8000_0008;
`ifdef FETCH_KERNEL_MODE_EN
    localparam bit KMODE = 1'b1;
`else
    localparam bit KMODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall_i, branch_i, exc_i, jump_i, irq_i;
    logic [31:0] branch_tgt_i, jump_tgt_i;
    logic [31:0] imem_addr_o, imem_instr_i, ifid_instr_o, ifid_pc4_o, k0_data_o;
    logic        ifid_valid_o, flush_id_o, k0_we_o;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .branch_i     (branch_i),
        .branch_tgt_i (branch_tgt_i),
        .exc_i        (exc_i),
        .jump_i       (jump_i),
        .jump_tgt_i   (jump_tgt_i),
        .irq_i        (irq_i),
        .imem_addr_o  (imem_addr_o),
        .imem_instr_i (imem_instr_i),
        .ifid_instr_o (ifid_instr_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_valid_o (ifid_valid_o),
        .flush_id_o   (flush_id_o),
        .k0_we_o      (k0_we_o),
        .k0_data_o    (k0_data_o)
    );

    // Instruction ROM: an address hash, so every fetched word is distinguishable.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction
    assign imem_instr_i = rom(imem_addr_o);

    function automatic logic [31:0] inc4(input logic [31:0] a);
        return KMODE ? {a[31], a[30:0] + 31'd4} : a + 32'd4;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] k0_data;
        logic        valid;
        logic        k0_we;
        logic        flush;
    } snap_t;

    snap_t       exp_q[$];
    snap_t       m;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every clock the DUT presents a new IF state; compare it with the oldest prediction.
    always @(posedge clk) begin
        snap_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc",         imem_addr_o,          e.pc);
            check("ifid_instr", ifid_instr_o,         e.instr);
            check("ifid_pc4",   ifid_pc4_o,           e.pc4);
            check("ifid_valid", 32'(ifid_valid_o),    32'(e.valid));
            check("flush_id",   32'(flush_id_o),      32'(e.flush));
            check("k0_we",      32'(k0_we_o),         32'(e.k0_we));
            check("k0_data",    k0_data_o,            e.k0_data);
        end
    end

    // Apply one cycle of inputs and predict the state the next rising edge must produce.
    task automatic drive(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                         input logic ex, input logic jp, input logic [31:0] jt, input logic iq);
        snap_t e;
        @(negedge clk);
        reset = rst; stall_i = st; branch_i = br; branch_tgt_i = bt;
        exc_i = ex; jump_i = jp; jump_tgt_i = jt; irq_i = iq;
        e       = m;
        e.flush = br | ex;
        e.k0_we = 1'b0;
        if (rst) begin
            e.pc = RST_V; e.instr = '0; e.pc4 = '0; e.valid = 1'b0; e.k0_data = '0;
        end else if (br || ex || jp || (iq && !st && !(KMODE && m.pc[31]))) begin
            e.instr = '0; e.pc4 = '0; e.valid = 1'b0;
            if (br) begin
                e.pc = bt;
            end else if (ex) begin
                e.pc = EXC_V; e.k0_we = 1'b1; e.k0_data = m.pc4;
            end else if (jp) begin
                e.pc = jt;
            end else begin
                e.pc = IRQ_V; e.k0_we = 1'b1; e.k0_data = m.pc;
            end
        end else if (!st) begin
            e.instr = rom(m.pc); e.pc4 = inc4(m.pc); e.valid = 1'b1; e.pc = inc4(m.pc);
        end
        m = e;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask
    task automatic jump_to(input logic [31:0] t, input logic iq);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, t, iq);
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; branch_i = 1'b0; exc_i = 1'b0;
        jump_i = 1'b0; irq_i = 1'b0; branch_tgt_i = '0; jump_tgt_i = '0;

        // Reset then free-running fetch from the reset vector.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        repeat (3) idle();

        // Stall at pc=0x10 for three cycles, then resume at 0x14.
        jump_to(32'h0000_000C, 1'b0);
        idle();
        repeat (3) drive(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        idle();

        // Branch outranks a concurrent exception, jump and irq.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        idle();

        // Exception with ifid_pc4=0x18 returns after the faulting instruction.
        jump_to(32'h0000_0014, 1'b0);
        idle();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        repeat (2) idle();

        // Interrupt at 0x40, held high in the handler, then `jr $26`.
        jump_to(32'h0000_0040, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        jump_to(32'h0000_0040, 1'b1);
        repeat (2) idle();

        // Irq blocked by stall; jump beats irq, irq taken the cycle after.
        jump_to(32'h0000_0080, 1'b0);
        repeat (2) drive(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        jump_to(32'h0000_0300, 1'b1);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        idle();

        // Address wrap and reset winning over a stall and a branch.
        jump_to(32'hFFFF_FFF8, 1'b0);
        repeat (3) idle();
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b1, 1'b0, '0, 1'b1);
        idle();

        // Randomized traffic; back-to-back accepts occur naturally.
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_st, r_br, r_ex, r_jp, r_iq;
            logic [31:0] r_bt, r_jt;
            r_rst = ($urandom_range(0, 99) < 2);
            r_st  = ($urandom_range(0, 99) < 20);
            r_br  = ($urandom_range(0, 99) < 8);
            r_ex  = ($urandom_range(0, 99) < 6);
            r_jp  = ($urandom_range(0, 99) < 10);
            r_iq  = ($urandom_range(0, 99) < 15);
            r_bt  = $urandom() & 32'hFFFF_FFFC;
            r_jt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
            drive(r_rst, r_st, r_br, r_bt, r_ex, r_jp, r_jt, r_iq);
        end

        @(posedge clk);
        #3;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
